mul_sequencer: RTL and testbench

Multi-cycle shift-add controller for the MUL instruction in the pipelined LEGv8 CPU. Decode steers MUL to ALUSrc 2'b11, which feeds this block instead of the single-cycle ALU. The block latches the operands, iterates one multiplier bit per cycle with early termination, and stalls the front of the pipeline while it works. It then holds the 64-bit low product for writeback until acknowledged, and aborts cleanly on a branch flush.

---
 rtl/mul_sequencer_if.sv | 41 ++++
 rtl/mul_sequencer.sv | 113 +++++++++++
 tb/tb_mul_sequencer.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mul_sequencer_if.sv
// ---------------------------------------------------------------------------
// mul_sequencer_if
// Bundles the EX-stage request side and the writeback result side of the
// multi-cycle MUL sequencer.
//   master : pipeline side (drives start/operands/flush/ack, sees results)
//   slave  : sequencer side (sees requests, drives stall/busy/results)
// Signals:
//   start, op_a, op_b, dest_in   - MUL launch request and operands
//   flush                        - branch-taken cancel
//   result_ack                   - writeback consumed the result
//   stall                        - combinational front-end freeze
//   busy, result, result_valid,
//   result_dest, cycle_count     - registered status and result
// ---------------------------------------------------------------------------
interface mul_sequencer_if #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned CNT_W = 7
);
    logic             start;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [4:0]       dest_in;
    logic             flush;
    logic             result_ack;
    logic             stall;
    logic             busy;
    logic [WIDTH-1:0] result;
    logic             result_valid;
    logic [4:0]       result_dest;
    logic [CNT_W-1:0] cycle_count;

    modport master (
        output start, op_a, op_b, dest_in, flush, result_ack,
        input  stall, busy, result, result_valid, result_dest, cycle_count
    );

    modport slave (
        input  start, op_a, op_b, dest_in, flush, result_ack,
        output stall, busy, result, result_valid, result_dest, cycle_count
    );
endinterface

// File: rtl/mul_sequencer.sv
// ---------------------------------------------------------------------------
// mul_sequencer
// Shift-add multiplier controller for the LEGv8 MUL instruction. Latches the
// operands on start, retires one multiplier bit per cycle and stops as soon
// as no set multiplier bits remain. The low WIDTH bits of the product are
// held for writeback until acknowledged; a flush aborts without touching the
// previously published result.
// Ports:
//   clk    - rising-edge clock
//   reset  - synchronous, active-high
//   bus    - mul_sequencer_if slave modport (request, stall, result)
// ---------------------------------------------------------------------------
module mul_sequencer #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned CNT_W = 7
) (
    input  logic           clk,
    input  logic           reset,
    mul_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q;      // multiplicand, shifted left each step
    logic [WIDTH-1:0] b_q;      // multiplier, shifted right each step
    logic [WIDTH-1:0] acc_q;    // running partial product
    logic [4:0]       dest_q;
    logic [CNT_W-1:0] cnt_q;

    logic [WIDTH-1:0] acc_sum;
    logic [WIDTH-1:0] b_shift;
    logic [CNT_W-1:0] cnt_inc;

    // One shift-add step; carry out of the top bit is dropped (truncated product).
    assign acc_sum = b_q[0] ? (acc_q + a_q) : acc_q;
    assign b_shift = b_q >> 1;
    assign cnt_inc = cnt_q + CNT_W'(1);

    // Front-end freeze: raised in the launch cycle, held through BUSY and DONE.
    assign bus.stall = bus.start | bus.busy;

    // Control FSM with datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            a_q              <= '0;
            b_q              <= '0;
            acc_q            <= '0;
            dest_q           <= '0;
            cnt_q            <= '0;
            bus.busy         <= 1'b0;
            bus.result_valid <= 1'b0;
            bus.result       <= '0;
            bus.result_dest  <= '0;
            bus.cycle_count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // Flush in the same cycle cancels the launch.
                    if (bus.start && !bus.flush) begin
                        a_q      <= bus.op_a;
                        b_q      <= bus.op_b;
                        acc_q    <= '0;
                        dest_q   <= bus.dest_in;
                        cnt_q    <= '0;
                        bus.busy <= 1'b1;
                        state    <= BUSY;
                    end
                end

                BUSY: begin
                    if (bus.flush) begin
                        bus.busy <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        acc_q <= acc_sum;
                        a_q   <= a_q << 1;
                        b_q   <= b_shift;
                        cnt_q <= cnt_inc;
                        // Early-out: nothing left to add once the multiplier is exhausted.
                        if (b_shift == '0) begin
                            bus.result       <= acc_sum;
                            bus.result_dest  <= dest_q;
                            bus.cycle_count  <= cnt_inc;
                            bus.result_valid <= 1'b1;
                            state            <= DONE;
                        end
                    end
                end

                DONE: begin
                    if (bus.flush || bus.result_ack) begin
                        bus.busy         <= 1'b0;
                        bus.result_valid <= 1'b0;
                        state            <= IDLE;
                    end
                end

                default: begin
                    bus.busy         <= 1'b0;
                    bus.result_valid <= 1'b0;
                    state            <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mul_sequencer
// Self-checking bench for mul_sequencer: directed scenarios plus randomized
// operations compared against an arithmetic reference (a*b truncated, cycle
// count from the multiplier's most-significant set bit).
// ---------------------------------------------------------------------------
module tb_mul_sequencer;

    localparam int unsigned WIDTH = 64;
    localparam int unsigned CNT_W = 7;
    localparam int unsigned TMO   = 200;

    logic clk;
    logic reset;

    int n_checks;
    int n_fail;

    // Last successfully completed operation, as predicted by the model.
    logic [63:0] exp_result;
    logic [4:0]  exp_dest;
    logic [6:0]  exp_cc;

    mul_sequencer_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    mul_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: number of BUSY cycles = index of top set bit + 1, minimum 1.
    function automatic int model_cycles(input logic [63:0] b);
        int n;
        n = 1;
        for (int i = 0; i < 64; i++) if (b[i]) n = i + 1;
        return n;
    endfunction

    function automatic logic [63:0] model_product(input logic [63:0] a, input logic [63:0] b);
        return a * b;
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, "_valid"}, 64'(bus.result_valid), 64'(0));
        check({tag, "_result"}, bus.result, exp_result);
        check({tag, "_dest"}, 64'(bus.result_dest), 64'(exp_dest));
        check({tag, "_cc"}, 64'(bus.cycle_count), 64'(exp_cc));
    endtask

    // Full operation: launch, wait for result, hold, acknowledge.
    task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                          input logic [4:0] d, input int hold, input bit poke);
        int ticks;
        int cyc;
        logic [63:0] prod;
        cyc  = model_cycles(b);
        prod = model_product(a, b);

        bus.start   = 1'b1;
        bus.op_a    = a;
        bus.op_b    = b;
        bus.dest_in = d;
        #1;
        check({tag, "_stall_launch"}, 64'(bus.stall), 64'(1));
        tick();
        ticks = 1;
        // Scramble the operand buses; optionally re-pulse start while busy.
        bus.start = poke;
        bus.op_a  = {$urandom, $urandom};
        bus.op_b  = {$urandom, $urandom};
        bus.dest_in = 5'($urandom);
        while (!bus.result_valid && ticks < TMO) begin
            tick();
            bus.start = 1'b0;
            ticks++;
        end
        bus.start = 1'b0;
        #1;
        check({tag, "_latency"}, 64'(ticks), 64'(cyc + 1));
        if (bus.result_valid) begin
            exp_result = prod;
            exp_dest   = d;
            exp_cc     = 7'(cyc);
        end
        check({tag, "_result"}, bus.result, prod);
        check({tag, "_dest"}, 64'(bus.result_dest), 64'(d));
        check({tag, "_cc"}, 64'(bus.cycle_count), 64'(cyc));
        check({tag, "_busy_done"}, 64'(bus.busy), 64'(1));
        check({tag, "_stall_done"}, 64'(bus.stall), 64'(1));
        for (int i = 0; i < hold; i++) begin
            tick();
            check({tag, "_hold_valid"}, 64'(bus.result_valid), 64'(1));
            check({tag, "_hold_result"}, bus.result, prod);
            check({tag, "_hold_stall"}, 64'(bus.stall), 64'(1));
        end
        bus.result_ack = 1'b1;
        tick();
        bus.result_ack = 1'b0;
        #1;
        check({tag, "_ack_valid"}, 64'(bus.result_valid), 64'(0));
        check({tag, "_ack_busy"}, 64'(bus.busy), 64'(0));
        check({tag, "_ack_stall"}, 64'(bus.stall), 64'(0));
        check({tag, "_ack_result"}, bus.result, prod);
    endtask

    initial begin
        logic [63:0] ra;
        logic [63:0] rb;
        n_checks = 0;
        n_fail   = 0;
        exp_result = '0;
        exp_dest   = '0;
        exp_cc     = '0;

        reset          = 1'b1;
        bus.start      = 1'b0;
        bus.op_a       = '0;
        bus.op_b       = '0;
        bus.dest_in    = '0;
        bus.flush      = 1'b0;
        bus.result_ack = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        check_outputs("reset");
        check("reset_busy", 64'(bus.busy), 64'(0));
        check("reset_stall", 64'(bus.stall), 64'(0));

        // Ack outside DONE is ignored.
        bus.result_ack = 1'b1;
        tick();
        bus.result_ack = 1'b0;
        check("idle_ack_busy", 64'(bus.busy), 64'(0));

        run_op("3x5", 64'd3, 64'd5, 5'd9, 5, 1'b0);
        run_op("neg3x7", 64'hFFFF_FFFF_FFFF_FFFD, 64'd7, 5'd1, 0, 1'b0);
        check("neg3x7_abs", exp_result, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op("ones_x2", 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd2, 1, 1'b0);
        run_op("b_zero", 64'd123, 64'd0, 5'd3, 0, 1'b0);
        run_op("b_msb", 64'd1, 64'h8000_0000_0000_0000, 5'd31, 0, 1'b0);

        // Flush on the 4th BUSY cycle of an 8-cycle op.
        bus.start = 1'b1;
        bus.op_a  = 64'd77;
        bus.op_b  = 64'hFF;
        bus.dest_in = 5'd20;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("flush_busy", 64'(bus.busy), 64'(0));
        check_outputs("flush");
        for (int i = 0; i < 10; i++) begin
            tick();
            check("flush_quiet", 64'(bus.result_valid | bus.busy), 64'(0));
        end

        // Start together with flush in IDLE: no launch.
        bus.start = 1'b1;
        bus.flush = 1'b1;
        bus.op_b  = 64'd3;
        tick();
        bus.start = 1'b0;
        bus.flush = 1'b0;
        check("startflush_busy", 64'(bus.busy), 64'(0));
        tick();
        check("startflush_busy2", 64'(bus.busy), 64'(0));

        // Flush while in DONE drops the valid without republishing.
        run_op("pre_dflush", 64'd11, 64'd13, 5'd4, 0, 1'b0);
        bus.start = 1'b1;
        bus.op_a  = 64'd5;
        bus.op_b  = 64'd1;
        bus.dest_in = 5'd6;
        tick();
        bus.start = 1'b0;
        tick();
        check("dflush_valid_pre", 64'(bus.result_valid), 64'(1));
        exp_result = 64'd5;
        exp_dest   = 5'd6;
        exp_cc     = 7'd1;
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check_outputs("dflush");

        // Reset on the 10th BUSY cycle of a 64-cycle op.
        bus.start = 1'b1;
        bus.op_a  = 64'h1234;
        bus.op_b  = 64'h8000_0000_0000_0001;
        bus.dest_in = 5'd17;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_result = '0;
        exp_dest   = '0;
        exp_cc     = '0;
        check_outputs("midreset");
        check("midreset_busy", 64'(bus.busy), 64'(0));
        check("midreset_stall", 64'(bus.stall), 64'(0));

        run_op("6x7_poke", 64'd6, 64'd7, 5'd12, 0, 1'b1);

        // Randomized operations with varied multiplier length and ack delay.
        for (int n = 0; n < 30; n++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom} >> $urandom_range(0, 63);
            run_op($sformatf("rnd%0d", n), ra, rb, 5'($urandom), int'($urandom_range(0, 3)),
                   1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
